// File: rtl/proc_sequencer.sv
// Control sequencer for a simple multi-cycle processor datapath: fetches an instruction word,
// then steps through up to three execute cycles that drive the bus, register and ALU controls.
module proc_sequencer #(
  parameter int unsigned NREG = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run_i,
  input  logic [15:0]     din_i,
  output logic [3:0]      bus_sel_o,
  output logic [NREG-1:0] reg_en_o,
  output logic            a_en_o,
  output logic            g_en_o,
  output logic [1:0]      alu_op_o,
  output logic            done_o,
  output logic            illegal_o,
  output logic [15:0]     retired_o
);

  localparam logic [3:0] BusDin  = 4'd8;
  localparam logic [3:0] BusG    = 4'd9;
  localparam logic [3:0] BusNone = 4'd15;

  localparam logic [2:0] OpMv  = 3'b000;
  localparam logic [2:0] OpMvi = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;

  localparam logic [1:0] AluAdd  = 2'd0;
  localparam logic [1:0] AluSub  = 2'd1;
  localparam logic [1:0] AluAnd  = 2'd2;
  localparam logic [1:0] AluPass = 2'd3;

  typedef enum logic [1:0] {StT0, StT1, StT2, StT3} state_e;

  state_e          state_q, state_d;
  logic [15:0]     ir_q, ir_d;
  logic [15:0]     retired_q, retired_d;
  logic [2:0]      op, rx, ry;
  logic [NREG-1:0] rx_onehot;

  assign op        = ir_q[15:13];
  assign rx        = ir_q[12:10];
  assign ry        = ir_q[9:7];
  assign rx_onehot = NREG'(1) << rx;
  assign retired_o = retired_q;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    bus_sel_o = BusNone;
    reg_en_o  = '0;
    a_en_o    = 1'b0;
    g_en_o    = 1'b0;
    alu_op_o  = AluPass;
    done_o    = 1'b0;
    illegal_o = 1'b0;

    unique case (state_q)
      StT0: begin
        if (run_i) begin
          bus_sel_o = BusDin;
          ir_d      = din_i;
          state_d   = StT1;
        end
      end
      StT1: begin
        state_d = StT0;
        unique case (op)
          OpMv: begin
            bus_sel_o = {1'b0, ry};
            reg_en_o  = rx_onehot;
            done_o    = 1'b1;
          end
          OpMvi: begin
            bus_sel_o = BusDin;
            reg_en_o  = rx_onehot;
            done_o    = 1'b1;
          end
          OpAdd, OpSub, OpAnd: begin
            bus_sel_o = {1'b0, rx};
            a_en_o    = 1'b1;
            state_d   = StT2;
          end
          default: begin
            done_o    = 1'b1;
            illegal_o = 1'b1;
          end
        endcase
      end
      StT2: begin
        bus_sel_o = {1'b0, ry};
        g_en_o    = 1'b1;
        state_d   = StT3;
        unique case (op)
          OpSub:   alu_op_o = AluSub;
          OpAnd:   alu_op_o = AluAnd;
          default: alu_op_o = AluAdd;
        endcase
      end
      StT3: begin
        bus_sel_o = BusG;
        reg_en_o  = rx_onehot;
        done_o    = 1'b1;
        state_d   = StT0;
      end
      default: state_d = StT0;
    endcase

    // Saturating count of legal completions.
    retired_d = retired_q;
    if (done_o && !illegal_o && (retired_q != 16'hFFFF)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StT0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Randomized self-checking bench for proc_sequencer: each instruction's expected cycle-by-cycle
// control outputs are derived from its class (move, immediate, ALU, illegal).
module tb_proc_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] din;
  logic [3:0]  bus_sel;
  logic [7:0]  reg_en;
  logic        a_en;
  logic        g_en;
  logic [1:0]  alu_op;
  logic        done;
  logic        illegal;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ret  = 0;
  logic [17:0] exp_q[$];
  logic [17:0] obs;

  proc_sequencer #(.NREG(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .run_i     (run),
    .din_i     (din),
    .bus_sel_o (bus_sel),
    .reg_en_o  (reg_en),
    .a_en_o    (a_en),
    .g_en_o    (g_en),
    .alu_op_o  (alu_op),
    .done_o    (done),
    .illegal_o (illegal),
    .retired_o (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus_sel, reg_en, a_en, g_en, alu_op, done, illegal};

  function automatic logic [17:0] pk(int bs, int re, bit a, bit g, int alu, bit d, bit il);
    logic [3:0] b4;
    logic [7:0] r8;
    logic [1:0] a2;
    b4 = bs[3:0];
    r8 = re[7:0];
    a2 = alu[1:0];
    return {b4, r8, a, g, a2, d, il};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outputs for each cycle after the fetch cycle, by instruction class.
  task automatic build_exp(input logic [15:0] instr);
    int op, rx, ry;
    op = int'(instr[15:13]);
    rx = int'(instr[12:10]);
    ry = int'(instr[9:7]);
    exp_q.delete();
    case (op)
      0: exp_q.push_back(pk(ry, 1 << rx, 0, 0, 3, 1, 0));
      1: exp_q.push_back(pk(8, 1 << rx, 0, 0, 3, 1, 0));
      2, 3, 4: begin
        exp_q.push_back(pk(rx, 0, 1, 0, 3, 0, 0));
        exp_q.push_back(pk(ry, 0, 0, 1, op - 2, 0, 0));
        exp_q.push_back(pk(9, 1 << rx, 0, 0, 3, 1, 0));
      end
      default: exp_q.push_back(pk(15, 0, 0, 0, 3, 1, 1));
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      run = 1'b0;
      din = 16'($urandom);
      #1 check_eq("idle", 32'(obs), 32'(pk(15, 0, 0, 0, 3, 0, 0)));
    end
  endtask

  // run_mode: 0 = drop run after fetch, 1 = hold run high, 2 = random run
  task automatic do_instr(input logic [15:0] instr, input logic [15:0] imm, input int run_mode);
    @(negedge clk);
    run = 1'b1;
    din = instr;
    #1 check_eq("fetch", 32'(obs), 32'(pk(8, 0, 0, 0, 3, 0, 0)));
    build_exp(instr);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      din = imm;
      run = (run_mode == 1) ? 1'b1 : (run_mode == 2) ? 1'($urandom) : 1'b0;
      #1 check_eq($sformatf("exec%0d ir=%h", i, instr), 32'(obs), 32'(exp_q[i]));
    end
    if (instr[15:13] <= 3'd4 && exp_ret < 65535) exp_ret++;
    @(posedge clk);
    #1 check_eq("retired", 32'(retired), 32'(exp_ret));
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    din   = 16'h0000;
    repeat (2) @(negedge clk);
    #1 check_eq("reset_out", 32'(obs), 32'(pk(15, 0, 0, 0, 3, 0, 0)));
    check_eq("reset_retired", 32'(retired), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // mvi R3,#0x00A5 ; add R1,R2 ; illegal ; sub with run dropped then idle ; add R2,R2
    do_instr(16'h2C00, 16'h00A5, 0);
    do_instr(16'h4500, 16'h0000, 0);
    do_instr(16'hE000, 16'h0000, 0);
    do_instr(16'h6A80, 16'h0000, 0);
    idle(3);
    do_instr(16'h4900, 16'h0000, 1);

    // Reset during T2 of an add aborts it with no done pulse.
    @(negedge clk);
    run = 1'b1;
    din = 16'h4500;
    @(negedge clk);
    run = 1'b0;
    #1 check_eq("abort_t1", 32'(obs), 32'(pk(1, 0, 1, 0, 3, 0, 0)));
    @(negedge clk);
    #1 check_eq("abort_t2", 32'(obs), 32'(pk(2, 0, 0, 1, 0, 0, 0)));
    reset = 1'b1;
    #1 check_eq("abort_out", 32'(obs), 32'(pk(15, 0, 0, 0, 3, 0, 0)));
    check_eq("abort_retired", 32'(retired), 32'd0);
    exp_ret = 0;
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    do_instr(16'h0380, 16'h0000, 0);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      do_instr(16'($urandom), 16'($urandom), 2);
    end

    // Saturation, with run held high back to back.
    @(negedge clk);
    run = 1'b0;
    force dut.retired_q = 16'hFFFD;
    #1 release dut.retired_q;
    exp_ret = 65533;
    for (int k = 0; k < 4; k++) do_instr(16'h0380, 16'h0000, 1);
    do_instr(16'h4500, 16'h0000, 1);
    do_instr(16'hA000, 16'h0000, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 Parameter NREG, default 8, number of general registers; fixed at 8 (3-bit register fields).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 run  input  1  start request; sampled only in state T0.
REQ-005 din  input  16  instruction word in T0; immediate data word in T1 for mvi.
REQ-006 bus_sel  output  4  bus source: 0-7 = R0-R7, 8 = din, 9 = G, 15 = none.
REQ-007 reg_en  output  8  one-hot register write enable; R[i] loads bus on the edge ending the cycle.
REQ-008 a_en  output  1  load ALU operand register A from bus.
REQ-009 g_en  output  1  load ALU result register G.
REQ-010 alu_op  output  2  0 = add, 1 = sub, 2 = and, 3 = pass.
REQ-011 done  output  1  one-cycle pulse in the final cycle of every instruction.
REQ-012 illegal  output  1  one-cycle pulse with done when the opcode is unsupported.
REQ-013 retired  output  16  count of completed legal instructions.

Function
REQ-014 The instruction register ir[15:0] shall be internal, with fields op = ir[15:13], rx = ir[12:10], ry = ir[9:7].
REQ-015 The FSM shall have exactly the states T0, T1, T2 and T3.
REQ-016 Defaults in every cycle: bus_sel = 15, reg_en = 0, a_en = g_en = done = illegal = 0, alu_op = 3.
REQ-017 T0, run = 0: hold in T0 with default outputs.
REQ-018 T0, run = 1: bus_sel = 8; ir loads din at the edge; next state T1.
REQ-019 T1, op = 000 (mv): bus_sel = ry, reg_en[rx] = 1, done = 1; next state T0.
REQ-020 T1, op = 001 (mvi): bus_sel = 8, reg_en[rx] = 1, done = 1; next state T0.
REQ-021 T1, op = 010/011/100 (add/sub/and): bus_sel = rx, a_en = 1; next state T2.
REQ-022 T2: bus_sel = ry, g_en = 1, alu_op = 0/1/2 for op 010/011/100; next state T3.
REQ-023 T3: bus_sel = 9, reg_en[rx] = 1, done = 1; next state T0.
REQ-024 T1, op = 101-111: done = 1, illegal = 1, no enables asserted; next state T0; retired unchanged.
REQ-025 run shall be ignored outside T0; deasserting run mid-instruction shall not abort it.
REQ-026 retired shall increment by 1 on each edge where done = 1 and illegal = 0, and shall saturate at 0xFFFF.
REQ-027 At most one bit of reg_en shall be high in any cycle; reg_en and a_en/g_en shall never be asserted together.
REQ-028 rx = ry shall be legal; the sequence is unchanged (e.g., add R2,R2 doubles R2).
REQ-029 run held high shall start the next instruction in the cycle immediately after done, with no idle cycle.
REQ-030 Latency from T0 with run = 1: mv/mvi/illegal 2 cycles, ALU ops 4 cycles.
REQ-031 All outputs except retired shall be combinational decodes of state and ir; state, ir and retired shall be registers.

Reset
REQ-032 reset = 1 shall immediately force state = T0, ir = 0 and retired = 0, so all outputs take their default values.
REQ-033 reset asserted mid-instruction shall abort the instruction with no done pulse; no further reg_en occurs until a new run.
REQ-034 After reset deasserts, the first possible instruction fetch shall be on the first rising edge with run = 1.

Verification
REQ-035 mvi R3,#0x00A5: T0 din = 0x2C00 with run = 1, T1 din = 0x00A5 -> T1 shows bus_sel = 8, reg_en = 0x08, done = 1; retired = 1.
REQ-036 add R1,R2 (din = 0x4500): cycle sequence -> (bus_sel 1, a_en), (bus_sel 2, g_en, alu_op 0), (bus_sel 9, reg_en 0x02, done); 4 cycles total.
REQ-037 Illegal op 0xE000 -> T1 shows done = 1, illegal = 1, reg_en = 0; retired unchanged; back in T0.
REQ-038 run dropped during T2 of a sub -> T3 still completes with done = 1; the FSM then idles in T0.
REQ-039 reset pulsed during T2 -> outputs at default immediately, retired = 0, no done pulse; the next run with mv R0,R7 completes in 2 cycles.
REQ-040 Preload retired near 0xFFFF via 65535 mv instructions (or force), then run 2 more -> retired holds at 0xFFFF; run held high back-to-back -> no idle cycles between instructions.
